// File: rtl/mcu_image_loader_pkg.sv
// Shared types and constants for the MCU image loader.
package mcu_image_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    CONV,
    WRITE,
    DONE
  } loader_state_t;

  localparam int LUMA_R     = 77;
  localparam int LUMA_G     = 150;
  localparam int LUMA_B     = 29;
  localparam int LUMA_SHIFT = 8;

endpackage

// File: rtl/mcu_image_loader_strobe_sync.sv
// Brings the asynchronous MCU byte strobe into clk and emits a one-cycle event
// on its synchronized rising edge, capturing the byte on that same edge.
module strobe_sync #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strobe,
  input  logic [DATA_W-1:0] data,
  output logic              evt,
  output logic [DATA_W-1:0] evt_data
);

  logic meta;
  logic sync;
  logic last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      last <= 1'b0;
      evt  <= 1'b0;
    end else begin
      meta <= strobe;
      sync <= meta;
      last <= sync;
      evt  <= sync & ~last;
    end
  end

  // Byte is sampled while the strobe is still guaranteed high.
  always_ff @(posedge clk) begin
    if (sync && !last) evt_data <= data;
  end

endmodule

// File: rtl/mcu_image_loader.sv
// MCU image loader: byte strobe in, one pixel per SRAM address out, raster order.
// Build option LOADER_GRAYSCALE_EN: three RGB bytes per pixel converted to luma.
module mcu_image_loader
  import mcu_image_loader_pkg::*;
#(
  parameter int IMAGEY           = 64,
  parameter int IMAGEX           = 64,
  parameter int IMAGE_SIZE       = IMAGEY * IMAGEX,
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
  parameter int RGB_SIZE         = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arm,
  input  logic                        abort,
  input  logic                        mcu_strobe,
  input  logic [RGB_SIZE-1:0]         mcu_data,
  output logic                        mcu_busy,
  output logic                        sram_wren,
  output logic [IMAGE_ADDR_WIDTH-1:0] sram_addr,
  output logic [RGB_SIZE-1:0]         sram_wdata,
  output logic                        image_loaded,
  output logic                        err_stray
);

  localparam logic [IMAGE_ADDR_WIDTH-1:0] LAST_PIX = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);

  loader_state_t               state;
  logic [IMAGE_ADDR_WIDTH-1:0] pix_cnt;
  logic                        wren_q;
  logic                        evt;
  logic [RGB_SIZE-1:0]         evt_data;
  logic [RGB_SIZE-1:0]         pix_val;

  strobe_sync #(.DATA_W(RGB_SIZE)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .strobe   (mcu_strobe),
    .data     (mcu_data),
    .evt      (evt),
    .evt_data (evt_data)
  );

`ifdef LOADER_GRAYSCALE_EN
  localparam int PROD_W = 2 * RGB_SIZE;

  logic [1:0]          chan_cnt;
  logic [RGB_SIZE-1:0] r_q;
  logic [RGB_SIZE-1:0] g_q;
  logic [RGB_SIZE-1:0] b_q;

  // Coefficients sum to 256, so the shifted sum always fits RGB_SIZE bits.
  function automatic logic [RGB_SIZE-1:0] luma(input logic [RGB_SIZE-1:0] r,
                                               input logic [RGB_SIZE-1:0] g,
                                               input logic [RGB_SIZE-1:0] b);
    logic [PROD_W-1:0] sum;
    sum = PROD_W'(r) * PROD_W'(LUMA_R) + PROD_W'(g) * PROD_W'(LUMA_G)
        + PROD_W'(b) * PROD_W'(LUMA_B);
    return RGB_SIZE'(sum >> LUMA_SHIFT);
  endfunction

  always_ff @(posedge clk) begin
    if (state == COLLECT && evt) begin
      case (chan_cnt)
        2'd0:    r_q <= evt_data;
        2'd1:    g_q <= evt_data;
        default: b_q <= evt_data;
      endcase
    end
  end

  assign pix_val = luma(r_q, g_q, b_q);
`else
  logic [RGB_SIZE-1:0] byte_q;

  always_ff @(posedge clk) begin
    if (state == COLLECT && evt) byte_q <= evt_data;
  end

  assign pix_val = byte_q;
`endif

  // An abort landing on the write cycle must not reach the SRAM.
  assign sram_wren = wren_q & ~abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pix_cnt      <= '0;
      wren_q       <= 1'b0;
      sram_addr    <= '0;
      sram_wdata   <= '0;
      image_loaded <= 1'b0;
      err_stray    <= 1'b0;
      mcu_busy     <= 1'b0;
`ifdef LOADER_GRAYSCALE_EN
      chan_cnt     <= 2'd0;
`endif
    end else begin
      wren_q       <= 1'b0;
      image_loaded <= 1'b0;
      mcu_busy     <= 1'b1;
      if (abort) begin
        state   <= IDLE;
        pix_cnt <= '0;
`ifdef LOADER_GRAYSCALE_EN
        chan_cnt <= 2'd0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (arm) begin
              state     <= COLLECT;
              err_stray <= 1'b0;
              pix_cnt   <= '0;
              mcu_busy  <= 1'b0;
`ifdef LOADER_GRAYSCALE_EN
              chan_cnt  <= 2'd0;
`endif
            end else if (evt) begin
              err_stray <= 1'b1;
            end
          end
          COLLECT: begin
            mcu_busy <= 1'b0;
            if (evt) begin
`ifdef LOADER_GRAYSCALE_EN
              if (chan_cnt == 2'd2) begin
                chan_cnt <= 2'd0;
                state    <= CONV;
                mcu_busy <= 1'b1;
              end else begin
                chan_cnt <= chan_cnt + 2'd1;
              end
`else
              state    <= CONV;
              mcu_busy <= 1'b1;
`endif
            end
          end
          CONV: begin
            wren_q     <= 1'b1;
            sram_addr  <= pix_cnt;
            sram_wdata <= pix_val;
            state      <= WRITE;
          end
          WRITE: begin
            if (pix_cnt == LAST_PIX) begin
              state        <= DONE;
              image_loaded <= 1'b1;
            end else begin
              pix_cnt  <= pix_cnt + 1'b1;
              state    <= COLLECT;
              mcu_busy <= 1'b0;
            end
          end
          DONE: begin
            pix_cnt <= '0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcu_image_loader.sv
// Scoreboard bench for mcu_image_loader: expected writes queued at stimulus time,
// popped and compared whenever the DUT asserts sram_wren.
module tb_mcu_image_loader;
  import mcu_image_loader_pkg::*;

  localparam int IMAGE_SIZE = 64 * 64;
  localparam int AW         = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          mcu_strobe = 1'b0;
  logic [7:0]    mcu_data = 8'h00;
  logic          mcu_busy;
  logic          sram_wren;
  logic [AW-1:0] sram_addr;
  logic [7:0]    sram_wdata;
  logic          image_loaded;
  logic          err_stray;

  mcu_image_loader dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .abort        (abort),
    .mcu_strobe   (mcu_strobe),
    .mcu_data     (mcu_data),
    .mcu_busy     (mcu_busy),
    .sram_wren    (sram_wren),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .image_loaded (image_loaded),
    .err_stray    (err_stray)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_rise = 0;
  int   n_writes = 0;
  int   n_loaded = 0;
  int   last_wr_addr = -1;
  int   last_wr_cyc = -10;
  int   exp_addr = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int exp_val(input int r, input int g, input int b);
`ifdef LOADER_GRAYSCALE_EN
    return (77 * r + 150 * g + 29 * b) / 256;
`else
    return r + 0 * (g + b);
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (sram_wren) begin
      if (q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("wr_addr", 32'(sram_addr), e.addr);
        check("wr_data", 32'(sram_wdata), e.data);
        check("wr_latency", cyc - last_rise, 5);
      end
      last_wr_addr = int'(sram_addr);
      last_wr_cyc  = cyc;
      n_writes++;
    end
    if (image_loaded) begin
      n_loaded++;
      check("loaded_after_last", last_wr_addr, IMAGE_SIZE - 1);
      check("loaded_timing", cyc - last_wr_cyc, 1);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit honour_busy);
    if (honour_busy) begin
      int i;
      for (i = 0; i < 50 && mcu_busy; i++) @(negedge clk);
      if (mcu_busy) check("busy_timeout", 1, 0);
    end
    mcu_data   = b;
    mcu_strobe = 1'b1;
    last_rise  = cyc;
    repeat (3) @(negedge clk);
    mcu_strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic push_exp(input int r, input int g, input int b);
    q.push_back('{addr: exp_addr, data: exp_val(r, g, b)});
    exp_addr = (exp_addr + 1) % IMAGE_SIZE;
  endtask

  task automatic send_pixel(input int r, input int g, input int b);
    push_exp(r, g, b);
`ifdef LOADER_GRAYSCALE_EN
    send_byte(8'(r), 1'b1);
    send_byte(8'(g), 1'b1);
    send_byte(8'(b), 1'b1);
`else
    send_byte(8'(r), 1'b1);
`endif
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    exp_addr = 0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    #1 check("abort_no_write", sram_wren, 0);
    @(negedge clk);
    abort = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) @(negedge clk);
    check("rst_wren", sram_wren, 0);
    check("rst_addr", 32'(sram_addr), 0);
    check("rst_wdata", 32'(sram_wdata), 0);
    check("rst_loaded", image_loaded, 0);
    check("rst_err", err_stray, 0);
    check("rst_busy", mcu_busy, 0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", mcu_busy, 1);

    // Bytes before arm are dropped and flagged.
    send_byte(8'h5A, 1'b0);
    send_byte(8'hA5, 1'b0);
    repeat (4) @(negedge clk);
    check("stray_err", err_stray, 1);
    check("stray_no_writes", n_writes, 0);
    pulse_arm();
    check("arm_clears_err", err_stray, 0);
    check("arm_busy", mcu_busy, 0);

    send_pixel(255, 255, 255);
    send_pixel(100, 0, 0);
    send_pixel(0, 200, 0);
    check("three_writes", n_writes, 3);

    // Pixels 3..10, then abort mid-image.
    for (int i = 3; i <= 10; i++) send_pixel(i * 23 % 256, i * 7 % 256, i * 91 % 256);
    check("eleven_writes", n_writes, 11);
    pulse_abort();
    @(negedge clk);
    check("abort_state", 32'(dut.state), 32'(IDLE));
    check("abort_busy", mcu_busy, 1);
    check("abort_err_kept", err_stray, 0);
    pulse_arm();
    send_pixel(17, 34, 51);
    check("rearm_write", n_writes, 12);

`ifndef LOADER_GRAYSCALE_EN
    // Full image of ramp bytes.
    pulse_abort();
    pulse_arm();
    n_loaded = 0;
    base = n_writes;
    for (int i = 0; i < IMAGE_SIZE; i++) send_pixel(i % 256, 0, 0);
    repeat (4) @(negedge clk);
    check("full_writes", n_writes - base, IMAGE_SIZE);
    check("full_loaded_once", n_loaded, 1);
    check("full_state", 32'(dut.state), 32'(IDLE));
    check("full_busy", mcu_busy, 1);
`endif

    // Asynchronous reset landing on the write cycle.
    pulse_abort();
    pulse_arm();
    push_exp(200, 10, 60);
`ifdef LOADER_GRAYSCALE_EN
    send_byte(8'd200, 1'b1);
    send_byte(8'd10, 1'b1);
    mcu_data = 8'd60;
`else
    mcu_data = 8'd200;
`endif
    mcu_strobe = 1'b1;
    last_rise  = cyc;
    for (int i = 0; i < 20 && !sram_wren; i++) @(negedge clk);
    check("rst_write_seen", sram_wren, 1);
    #2 rst = 1'b1;
    #1;
    mcu_strobe = 1'b0;
    check("arst_wren", sram_wren, 0);
    check("arst_addr", 32'(sram_addr), 0);
    check("arst_wdata", 32'(sram_wdata), 0);
    check("arst_loaded", image_loaded, 0);
    check("arst_err", err_stray, 0);
    check("arst_busy", mcu_busy, 0);
    check("arst_state", 32'(dut.state), 32'(IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
